// File: rtl/cam_pkg.sv
// Shared types and constants for the camera test-pattern source: FSM states,
// pattern_sel encodings, and the eight RGB565 colour-bar values.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } cam_state_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_SOLID = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_CHECK = 2'd3
    } cam_pat_t;

    localparam int COORD_W = 16;
    localparam logic [7:0] STAMP_TAG = 8'hA5;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_pattern_source_if.sv
// Emulated OV-style sensor bus driven by the pattern source.
interface cam_pattern_source_if;
    // Bus protocol: href high marks a valid byte in data; every change happens
    // on the pclk falling edge, so a receiver samples data on the pclk rising edge.
    logic       pclk;
    logic       href;
    logic       vsync;
    logic [7:0] data;

    modport master (output pclk, output href, output vsync, output data);
    modport slave  (input  pclk, input  href, input  vsync, input  data);
endinterface

// File: rtl/cam_pattern_gen.sv
// Combinational pixel mapper: (pattern, x, y, solid colour) -> RGB565 pixel.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  cam_pat_t             pattern_i,
    input  logic [COORD_W-1:0]   x_i,
    input  logic [COORD_W-1:0]   y_i,
    input  logic [15:0]          solid_i,
    output logic [15:0]          pixel_o
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;
    logic       check_cell;

    always_comb begin
        bar_idx    = 3'(x_i / COORD_W'(BAR_W));
        check_cell = ((x_i ^ y_i) & COORD_W'(8)) != '0;
        pixel_o    = BAR_BLACK;
        case (pattern_i)
            PAT_BARS:  pixel_o = bar_color(bar_idx);
            PAT_SOLID: pixel_o = solid_i;
            PAT_GRAD:  pixel_o = {x_i[4:0], x_i[5:0], x_i[4:0]};
            PAT_CHECK: pixel_o = check_cell ? BAR_WHITE : BAR_BLACK;
            default:   pixel_o = BAR_BLACK;
        endcase
    end

endmodule

// File: rtl/cam_pattern_source.sv
// Camera-side transmitter emitting RGB565 test frames on an OV-style bus.
// Optional build macro CAM_FRAME_STAMP_EN adds frame_count and a per-frame stamp pixel.
module cam_pattern_source
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          enable,
    input  logic [1:0]                    pattern_sel,
    input  logic [15:0]                   solid_rgb,
    cam_pattern_source_if.master          bus,
    output logic                          busy,
    output logic                          frame_done,
`ifdef CAM_FRAME_STAMP_EN
    output logic [7:0]                    frame_count,
`endif
    output cam_state_t                    state_dbg
);

    localparam int          LINE     = 2 * H_ACTIVE + H_BLANK;
    localparam logic [15:0] H_LAST   = 16'(LINE - 1);
    localparam logic [15:0] HREF_LEN = 16'(2 * H_ACTIVE);
    localparam logic [15:0] DIV_LAST = 16'(PCLK_DIV - 1);

    cam_state_t  state_q, state_d;
    logic [15:0] div_q, div_d;
    logic        pclk_q, pclk_d;
    logic [15:0] h_q, h_d;
    logic [15:0] line_q, line_d;
    logic        href_q, href_d;
    logic        vsync_q, vsync_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    cam_pat_t    pat_q, pat_d;
    logic [15:0] solid_q, solid_d;

    logic        fall;
    logic        frame_end;
    logic [15:0] last_line;
    logic [15:0] gen_pixel;
    logic [15:0] pixel;

`ifdef CAM_FRAME_STAMP_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            pclk_q  <= 1'b0;
            h_q     <= '0;
            line_q  <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            h_q     <= h_d;
            line_q  <= line_d;
            href_q  <= href_d;
            vsync_q <= vsync_d;
            data_q  <= data_d;
            done_q  <= done_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
        end
    end

`ifdef CAM_FRAME_STAMP_EN
    always_ff @(posedge clk or posedge res) begin
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    // Frame position advances once per pclk period, on the pclk 1->0 edge.
    always_comb begin
        fall      = (state_q != ST_IDLE) && (div_q == DIV_LAST) && pclk_q;
        frame_end = 1'b0;
        state_d   = state_q;
        h_d       = h_q;
        line_d    = line_q;
        last_line = '0;
        case (state_q)
            ST_VSYNC:  last_line = 16'(VSYNC_LINES - 1);
            ST_VBACK:  last_line = 16'(V_BACK - 1);
            ST_ACTIVE: last_line = 16'(V_ACTIVE - 1);
            ST_VFRONT: last_line = 16'(V_FRONT - 1);
            default:   last_line = '0;
        endcase

        if (state_q == ST_IDLE) begin
            if (enable) begin
                state_d = ST_VSYNC;
                h_d     = '0;
                line_d  = '0;
            end
        end else if (fall) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (line_q == last_line) begin
                    line_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBACK;
                        ST_VBACK:  state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFRONT;
                        ST_VFRONT: begin
                            frame_end = 1'b1;
                            state_d   = enable ? ST_VSYNC : ST_IDLE;
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    line_d = line_q + 16'd1;
                end
            end else begin
                h_d = h_q + 16'd1;
            end
        end
    end

    cam_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_gen (
        .pattern_i (pat_q),
        .x_i       ({1'b0, h_d[15:1]}),
        .y_i       (line_d),
        .solid_i   (solid_q),
        .pixel_o   (gen_pixel)
    );

`ifdef CAM_FRAME_STAMP_EN
    assign pixel = (h_d < 16'd2 && line_d == '0) ? {STAMP_TAG, cnt_q} : gen_pixel;
`else
    assign pixel = gen_pixel;
`endif

    always_comb begin
        div_d   = div_q;
        pclk_d  = pclk_q;
        href_d  = href_q;
        vsync_d = vsync_q;
        data_d  = data_q;
        done_d  = frame_end;
        pat_d   = pat_q;
        solid_d = solid_q;
`ifdef CAM_FRAME_STAMP_EN
        cnt_d   = frame_end ? cnt_q + 8'd1 : cnt_q;
`endif

        if (state_q == ST_IDLE) begin
            div_d  = '0;
            pclk_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            pclk_d = ~pclk_q;
        end else begin
            div_d  = div_q + 16'd1;
        end

        // Pattern settings are frozen for the whole frame at VSYNC entry.
        if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
            pat_d   = cam_pat_t'(pattern_sel);
            solid_d = solid_rgb;
        end

        if (fall || state_q == ST_IDLE) begin
            vsync_d = (state_d == ST_VSYNC);
            href_d  = (state_d == ST_ACTIVE) && (h_d < HREF_LEN);
            data_d  = href_d ? (h_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
        end
    end

    assign bus.pclk   = pclk_q;
    assign bus.href   = href_q;
    assign bus.vsync  = vsync_q;
    assign bus.data   = data_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign state_dbg  = state_q;
`ifdef CAM_FRAME_STAMP_EN
    assign frame_count = cnt_q;
`endif

endmodule

// File: tb/tb_cam_pattern_source.sv
// Directed-plus-random bench for cam_pattern_source with a frame-level byte model.
module tb_cam_pattern_source;
    import cam_pkg::*;

    localparam int H_ACTIVE    = 16;
    localparam int V_ACTIVE    = 4;
    localparam int H_BLANK     = 4;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int PCLK_DIV    = 1;
    localparam int LINE        = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_CLK   = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LINE * 2 * PCLK_DIV;

`ifdef CAM_FRAME_STAMP_EN
    localparam bit STAMP_ON = 1'b1;
`else
    localparam bit STAMP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_rgb;
    logic        busy;
    logic        frame_done;
    cam_state_t  state_dbg;
`ifdef CAM_FRAME_STAMP_EN
    logic [7:0]  frame_count;
`endif

    cam_pattern_source_if bus_if ();

    cam_pattern_source #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT),
        .PCLK_DIV    (PCLK_DIV)
    ) dut (
        .clk         (clk),
        .res         (res),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .bus         (bus_if),
        .busy        (busy),
        .frame_done  (frame_done),
`ifdef CAM_FRAME_STAMP_EN
        .frame_count (frame_count),
`endif
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_pixel(input int pat, input logic [15:0] solid,
                                                input int x, input int y, input int fidx);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        if (STAMP_ON && x == 0 && y == 0) return {8'hA5, 8'(fidx)};
        case (pat)
            0:       return bars[x / (H_ACTIVE / 8)];
            1:       return solid;
            2:       return 16'(((x % 32) << 11) | ((x % 64) << 5) | (x % 32));
            default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic build_expected(input int pat, input logic [15:0] solid, input int fidx);
        logic [15:0] p;
        exp_q.delete();
        for (int y = 0; y < V_ACTIVE; y++) begin
            for (int x = 0; x < H_ACTIVE; x++) begin
                p = model_pixel(pat, solid, x, y, fidx);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    // Watches one whole frame; cycle 1 is the first falling clk edge after the task starts.
    task automatic run_frame(input int pat, input logic [15:0] solid, input int fidx,
                             input int exp_done, input int chg_cyc, input logic [1:0] chg_sel,
                             input logic [15:0] chg_solid, input int drop_cyc);
        logic [7:0] got_q[$];
        int href_len_q[$];
        int cyc, vs_cnt, run, bad_idle, busy_low, done_cyc, n;
        build_expected(pat, solid, fidx);
        cyc = 0; vs_cnt = 0; run = 0; bad_idle = 0; busy_low = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < FRAME_CLK + 50) begin
            @(negedge clk);
            cyc++;
            if (frame_done) done_cyc = cyc;
            else if (!busy) busy_low++;
            if (bus_if.pclk) begin
                if (bus_if.vsync) vs_cnt++;
                if (bus_if.href) begin
                    got_q.push_back(bus_if.data);
                    run++;
                end else begin
                    if (bus_if.data !== 8'h00) bad_idle++;
                    if (run > 0) begin
                        href_len_q.push_back(run);
                        run = 0;
                    end
                end
            end
            if (cyc == chg_cyc) begin
                pattern_sel = chg_sel;
                solid_rgb   = chg_solid;
            end
            if (cyc == drop_cyc) enable = 1'b0;
        end
        if (run > 0) href_len_q.push_back(run);

        check($sformatf("f%0d_done_cycle", fidx), done_cyc, exp_done);
        check($sformatf("f%0d_vsync_pclks", fidx), vs_cnt, VSYNC_LINES * LINE);
        check($sformatf("f%0d_href_pulses", fidx), href_len_q.size(), V_ACTIVE);
        foreach (href_len_q[i])
            check($sformatf("f%0d_href_len%0d", fidx, i), href_len_q[i], 2 * H_ACTIVE);
        check($sformatf("f%0d_data_when_href_low", fidx), bad_idle, 0);
        check($sformatf("f%0d_busy_drop", fidx), busy_low, 0);
        check($sformatf("f%0d_byte_count", fidx), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("f%0d_byte%0d", fidx, i), got_q[i], exp_q[i]);
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int pclk_hi, busy_hi, done_hi;
        pclk_hi = 0; busy_hi = 0; done_hi = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus_if.pclk !== 1'b0) pclk_hi++;
            if (busy !== 1'b0) busy_hi++;
            if (frame_done !== 1'b0) done_hi++;
        end
        check({tag, "_pclk_idle"}, pclk_hi, 0);
        check({tag, "_busy_idle"}, busy_hi, 0);
        check({tag, "_no_frame_done"}, done_hi, 0);
    endtask

    initial begin
        int sel;
        logic [15:0] sol;
        int n;

        res = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_pclk", bus_if.pclk, 0);
        check("rst_href", bus_if.href, 0);
        check("rst_vsync", bus_if.vsync, 0);
        check("rst_data", bus_if.data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
`ifdef CAM_FRAME_STAMP_EN
        check("rst_frame_count", frame_count, 0);
`endif
        res = 1'b0;
        idle_watch("post_rst", 5);

        // Frame 0 bars; switch to checker mid-ACTIVE, frame 1 checker, frame 2 solid.
        pattern_sel = 2'd0;
        enable = 1'b1;
        run_frame(0, 16'h0000, 0, FRAME_CLK + 1, 250, 2'd3, 16'h0000, -1);
        run_frame(3, 16'h0000, 1, FRAME_CLK, 100, 2'd1, 16'h1234, -1);
        run_frame(1, 16'h1234, 2, FRAME_CLK, -1, 2'd0, 16'h0000, 100);
        check("en_drop_busy_low", busy, 0);
        idle_watch("en_drop", 20);
`ifdef CAM_FRAME_STAMP_EN
        check("frame_count_3", frame_count, 3);
`endif

        for (int r = 0; r < 3; r++) begin
            sel = int'($urandom_range(0, 3));
            sol = 16'($urandom);
            pattern_sel = 2'(sel);
            solid_rgb   = sol;
            enable = 1'b1;
            run_frame(sel, sol, 3 + r, FRAME_CLK + 1, -1, 2'd0, 16'h0000,
                      int'($urandom_range(2, 450)));
        end
`ifdef CAM_FRAME_STAMP_EN
        check("frame_count_6", frame_count, 6);
`endif

        // Reset while a line is being sent.
        pattern_sel = 2'd0;
        enable = 1'b1;
        repeat (200) @(negedge clk);
        n = 0;
        while (!bus_if.href && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("midframe_href_seen", bus_if.href, 1);
        res = 1'b1;
        #1;
        check("midrst_pclk", bus_if.pclk, 0);
        check("midrst_href", bus_if.href, 0);
        check("midrst_vsync", bus_if.vsync, 0);
        check("midrst_data", bus_if.data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_done", frame_done, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        idle_watch("after_midrst", FRAME_CLK + 100);
`ifdef CAM_FRAME_STAMP_EN
        check("frame_count_after_rst", frame_count, 0);
`endif

        pattern_sel = 2'd2;
        enable = 1'b1;
        run_frame(2, 16'h0000, 0, FRAME_CLK + 1, -1, 2'd0, 16'h0000, 10);
        check("restart_busy_low", busy, 0);
`ifdef CAM_FRAME_STAMP_EN
        check("frame_count_1", frame_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
